fetch_prefetch_unit: RTL

//  Fetch stage feeding the decode pipeline register (instructionD/PCD/PCPlus4D).

---
 rtl/fetch_prefetch_unit_pkg.sv | 21 ++
 rtl/fetch_prefetch_unit_queue.sv | 73 +++++++
 rtl/fetch_prefetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and types for the fetch/prefetch stage.
package fetch_prefetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0]        DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch result: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [XLEN-1:0]        pc;
    } fetch_entry_t;

    // Sequential PC; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Parameterised circular FIFO used for the instruction queue and the in-flight PC shadow.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full queue is only taken when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order requests to instruction memory,
// buffers returned words with their PCs and presents one instruction per cycle.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_target,
    input  logic                   stall,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instructionF,
    output logic [XLEN-1:0]        PCF,
    output logic [XLEN-1:0]        PCPlus4F
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW:0]     credit_used;

    logic            issue;
    logic            resp_live;
    logic            iq_push;
    logic            iq_pop;
    fetch_entry_t    iq_push_data;
    fetch_entry_t    iq_head;
    logic            iq_full;
    logic            iq_empty;
    logic [CW-1:0]   iq_count;

    logic [XLEN-1:0] sh_head;
    logic            sh_full;
    logic            sh_empty;
    logic [CW-1:0]   sh_count;

    // Request channel: a request transfers on every edge where imem_req_valid and
    // imem_req_ready are both high; an unaccepted request holds its address until
    // taken, and is only withdrawn by redirect or reset.
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, iq_count};
    assign imem_req_valid = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;

    // With nothing outstanding a response can only be stale, so it is ignored.
    assign resp_live = imem_resp_valid && (outstanding_q != '0);
    assign iq_push   = resp_live && (drop_q == '0) && !redirect;
    assign iq_pop    = instr_valid && !stall && !redirect;

    always_comb begin
        iq_push_data       = '0;
        iq_push_data.instr = imem_resp_data;
        iq_push_data.pc    = sh_head;
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(resp_live);
        drop_d        = drop_q;
        if (redirect) begin
            pc_d   = redirect_target & 32'hFFFF_FFFC;
            // Everything still in flight after this cycle belongs to the old path.
            drop_d = outstanding_q - CW'(resp_live);
        end else begin
            if (issue) begin
                pc_d = pc_next(pc_q);
            end
            if (resp_live && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (iq_push),
        .push_data (iq_push_data),
        .pop       (iq_pop),
        .head_data (iq_head),
        .full      (iq_full),
        .empty     (iq_empty),
        .count     (iq_count)
    );

    // PC of every request in flight; dropped requests are popped with their responses.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_shadow (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (issue),
        .push_data (pc_q),
        .pop       (resp_live),
        .head_data (sh_head),
        .full      (sh_full),
        .empty     (sh_empty),
        .count     (sh_count)
    );

    assign instr_valid  = !iq_empty;
    assign instructionF = instr_valid ? iq_head.instr : NOP_INSTR;
    assign PCF          = instr_valid ? iq_head.pc : '0;
    assign PCPlus4F     = pc_next(PCF);

    assert property (@(posedge clk) disable iff (reset) !(resp_live && iq_full));
    assert property (@(posedge clk) disable iff (reset) !(issue && sh_full));
    assert property (@(posedge clk) disable iff (reset) sh_count == outstanding_q);
    assert property (@(posedge clk) disable iff (reset) sh_empty == (outstanding_q == '0));
    assert property (@(posedge clk) disable iff (reset)
        (imem_req_valid && !imem_req_ready) |=> (redirect || (imem_req_valid && $stable(imem_req_addr))));

endmodule
